// File: rtl/keypad_scanner_if.sv
// Keypad scanner bundle: enable/row returns in, column strobes and debounced key events out.
interface keypad_scanner_if;
  logic       enable;
  logic [3:0] row_in;
  logic [2:0] col_out;
  logic       key_valid;
  logic [3:0] key_code;
  logic       key_held;

  modport master (output enable, row_in, input col_out, key_valid, key_code, key_held);
  modport slave  (input enable, row_in, output col_out, key_valid, key_code, key_held);
endinterface

// File: rtl/keypad_scanner.sv
// 3x4 keypad front end: column strobing, row synchronizer, frame debounce and press events.
// state   | meaning
// IDLE    | no key accepted, waiting for a single-key frame
// CONFIRM | counting identical single-key frames for candidate key
// HELD    | press reported, waiting for an empty frame
// RELEASE | counting empty frames before accepting a new press
module keypad_scanner #(
  parameter int SCAN_DIV        = 65000,
  parameter int DEBOUNCE_FRAMES = 10
) (
  input  logic           clock_65mhz,
  input  logic           reset_n,
  keypad_scanner_if.slave kp
);
  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CNT_W = ($clog2(DEBOUNCE_FRAMES + 1) < 4) ? 4 : $clog2(DEBOUNCE_FRAMES + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE_FRAMES);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {S_IDLE, S_CONFIRM, S_HELD, S_RELEASE} state_t;
  typedef enum logic [1:0] {F_NONE, F_SINGLE, F_MULTI} frame_class_t;

  logic [3:0]       row_meta, row_sync;
  logic             active;
  logic [DIV_W-1:0] div;
  logic [1:0]       col_idx;
  logic [11:0]      frame;
  logic             frame_done;
  logic             tick;
  frame_class_t     cls, cls_q;
  logic [3:0]       bit_idx, ones, code, code_q;
  logic             cls_valid;
  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n, cnt_inc;
  logic [3:0]       cand, cand_n, key_code_q, key_code_n;
  logic             key_valid_q, key_valid_n;

  function automatic logic [3:0] key_map(input logic [3:0] b);
    case (b)
      4'd0: key_map = 4'd1;   4'd1: key_map = 4'd4;   4'd2:  key_map = 4'd7;  4'd3:  key_map = 4'd10;
      4'd4: key_map = 4'd2;   4'd5: key_map = 4'd5;   4'd6:  key_map = 4'd8;  4'd7:  key_map = 4'd0;
      4'd8: key_map = 4'd3;   4'd9: key_map = 4'd6;   4'd10: key_map = 4'd9;  4'd11: key_map = 4'd11;
      default: key_map = 4'd0;
    endcase
  endfunction

  always_ff @(posedge clock_65mhz or negedge reset_n) begin
    if (!reset_n) begin
      row_meta <= '0;
      row_sync <= '0;
    end else begin
      row_meta <= kp.row_in;
      row_sync <= row_meta;
    end
  end

  assign tick = active && (div == DIV_LAST);

  // active lags enable by one cycle so a restart gives column 0 its full dwell
  always_ff @(posedge clock_65mhz or negedge reset_n) begin
    if (!reset_n) begin
      active     <= 1'b1;
      div        <= '0;
      col_idx    <= '0;
      frame      <= '0;
      frame_done <= 1'b0;
    end else if (!kp.enable) begin
      active     <= 1'b0;
      div        <= '0;
      col_idx    <= '0;
      frame      <= '0;
      frame_done <= 1'b0;
    end else begin
      active     <= 1'b1;
      frame_done <= 1'b0;
      if (tick) begin
        div <= '0;
        frame[{col_idx, 2'b00} +: 4] <= row_sync;
        if (col_idx == 2'd2) begin
          col_idx    <= '0;
          frame_done <= 1'b1;
        end else begin
          col_idx <= col_idx + 2'd1;
        end
      end else if (active) begin
        div <= div + 1'b1;
      end
    end
  end

  always_comb begin
    ones    = '0;
    bit_idx = '0;
    for (int i = 0; i < 12; i++) begin
      if (frame[i]) begin
        ones    = ones + 4'd1;
        bit_idx = 4'(i);
      end
    end
    if (ones == 4'd0)      cls = F_NONE;
    else if (ones == 4'd1) cls = F_SINGLE;
    else                   cls = F_MULTI;
    code = key_map(bit_idx);
  end

  always_ff @(posedge clock_65mhz or negedge reset_n) begin
    if (!reset_n) begin
      cls_valid <= 1'b0;
      cls_q     <= F_NONE;
      code_q    <= '0;
    end else if (!kp.enable) begin
      cls_valid <= 1'b0;
      cls_q     <= F_NONE;
      code_q    <= '0;
    end else begin
      cls_valid <= frame_done;
      cls_q     <= cls;
      code_q    <= code;
    end
  end

  always_ff @(posedge clock_65mhz or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      cnt         <= '0;
      cand        <= '0;
      key_valid_q <= 1'b0;
      key_code_q  <= '0;
    end else if (!kp.enable) begin
      state       <= S_IDLE;
      cnt         <= '0;
      cand        <= '0;
      key_valid_q <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      cand        <= cand_n;
      key_valid_q <= key_valid_n;
      key_code_q  <= key_code_n;
    end
  end

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    cand_n      = cand;
    key_code_n  = key_code_q;
    key_valid_n = 1'b0;
    cnt_inc     = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
    if (cls_valid) begin
      case (state)
        S_IDLE: begin
          if (cls_q == F_SINGLE) begin
            cand_n  = code_q;
            cnt_n   = CNT_W'(1);
            state_n = S_CONFIRM;
          end
        end
        S_CONFIRM: begin
          if (cls_q == F_SINGLE && code_q == cand) begin
            cnt_n = cnt_inc;
            if (cnt_inc == CNT_DONE) begin
              key_valid_n = 1'b1;
              key_code_n  = cand;
              cnt_n       = '0;
              state_n     = S_HELD;
            end
          end else begin
            cnt_n   = '0;
            state_n = S_IDLE;
          end
        end
        S_HELD: begin
          if (cls_q == F_NONE) begin
            cnt_n   = CNT_W'(1);
            state_n = S_RELEASE;
          end
        end
        S_RELEASE: begin
          if (cls_q == F_NONE) begin
            cnt_n = cnt_inc;
            if (cnt_inc == CNT_DONE) begin
              cnt_n   = '0;
              state_n = S_IDLE;
            end
          end else begin
            cnt_n   = '0;
            state_n = S_HELD;
          end
        end
        default: begin
          cnt_n   = '0;
          state_n = S_IDLE;
        end
      endcase
    end
  end

  assign kp.col_out   = active ? (3'b001 << col_idx) : 3'b000;
  assign kp.key_valid = key_valid_q;
  assign kp.key_code  = key_code_q;
  assign kp.key_held  = (state == S_HELD) || (state == S_RELEASE);
endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a behavioural keypad driving rows from the strobes.
module tb_keypad_scanner;
  logic        clk = 1'b0;
  logic        reset_n;
  logic [11:0] keys;
  int          compared = 0;
  int          mismatched = 0;
  int          pulse_total = 0;
  int          pulse_mark = 0;
  int          viol = 0;
  logic        prev_valid = 1'b0;

  keypad_scanner_if kp ();

  keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_FRAMES(3)) dut (
    .clock_65mhz(clk),
    .reset_n    (reset_n),
    .kp         (kp)
  );

  always #5 clk = ~clk;

  // membrane model: a pressed key connects its column strobe to its row
  always_comb begin
    logic [3:0] r;
    r = 4'b0;
    for (int c = 0; c < 3; c++)
      if (kp.col_out[c]) r = r | keys[c*4 +: 4];
    kp.row_in = r;
  end

  always @(negedge clk) begin
    if (kp.key_valid) begin
      pulse_total++;
      if (!kp.enable || !reset_n || prev_valid) viol++;
    end
    prev_valid = kp.key_valid;
  end

  typedef struct {
    logic [11:0] keys;
    int          frames;
    int          pulses;
    int          code;
    int          held;
  } vec_t;

  vec_t vecs[22];

  task automatic chk(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_frame_start();
    logic [2:0] prev;
    bit         found;
    int         n;
    prev  = kp.col_out;
    found = 1'b0;
    n     = 0;
    while (!found && n < 100) begin
      @(posedge clk); #1;
      n++;
      if (kp.col_out == 3'b001 && prev != 3'b001) found = 1'b1;
      prev = kp.col_out;
    end
    if (!found) begin
      compared++;
      mismatched++;
      $display("FAIL frame_timeout: got no frame start expected one within 100 cycles");
    end
  endtask

  task automatic chk_vec(input int i);
    int p;
    p = pulse_total - pulse_mark;
    pulse_mark = pulse_total;
    chk($sformatf("vec%0d_pulses", i), p, vecs[i].pulses);
    chk($sformatf("vec%0d_code", i), int'(kp.key_code), vecs[i].code);
    chk($sformatf("vec%0d_held", i), int'(kp.key_held), vecs[i].held);
  endtask

  initial begin
    int exp_col;
    vecs[0]  = '{12'h000, 2,  0, 0, 0};
    vecs[1]  = '{12'h020, 13, 1, 5, 1};
    vecs[2]  = '{12'h000, 3,  0, 5, 0};
    vecs[3]  = '{12'h400, 1,  0, 5, 0};
    vecs[4]  = '{12'h000, 1,  0, 5, 0};
    vecs[5]  = '{12'h400, 2,  0, 5, 0};
    vecs[6]  = '{12'h400, 1,  1, 9, 1};
    vecs[7]  = '{12'h000, 3,  0, 9, 0};
    vecs[8]  = '{12'h801, 10, 0, 9, 0};
    vecs[9]  = '{12'h000, 1,  0, 9, 0};
    vecs[10] = '{12'h010, 3,  1, 2, 1};
    vecs[11] = '{12'h000, 2,  0, 2, 1};
    vecs[12] = '{12'h010, 2,  0, 2, 1};
    vecs[13] = '{12'h030, 2,  0, 2, 1};
    vecs[14] = '{12'h000, 3,  0, 2, 0};
    vecs[15] = '{12'h080, 3,  1, 0, 1};
    vecs[16] = '{12'h000, 3,  0, 0, 0};
    vecs[17] = '{12'h100, 2,  0, 0, 0};
    vecs[18] = '{12'h200, 2,  0, 0, 0};
    vecs[19] = '{12'h200, 1,  0, 0, 0};
    vecs[20] = '{12'h200, 1,  1, 6, 1};
    vecs[21] = '{12'h000, 3,  0, 6, 0};

    reset_n   = 1'b0;
    kp.enable = 1'b1;
    keys      = 12'h000;
    #12;
    chk("rst_col_out", int'(kp.col_out), 1);
    chk("rst_key_valid", int'(kp.key_valid), 0);
    chk("rst_key_code", int'(kp.key_code), 0);
    chk("rst_key_held", int'(kp.key_held), 0);
    #10 reset_n = 1'b1;

    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); #1;
      exp_col = (k < 4) ? 1 : (k < 8) ? 2 : (k < 12) ? 4 : 1;
      chk($sformatf("scan_col_cycle%0d", k), int'(kp.col_out), exp_col);
    end

    wait_frame_start();
    for (int i = 0; i < 22; i++) begin
      keys = vecs[i].keys;
      if (i > 0) begin
        repeat (4) @(posedge clk);
        #1;
        chk_vec(i - 1);
      end
      for (int f = 0; f < vecs[i].frames; f++) wait_frame_start();
    end
    keys = 12'h000;
    repeat (4) @(posedge clk);
    #1;
    chk_vec(21);

    // async reset in the middle of a confirm sequence for key 8
    wait_frame_start();
    keys = 12'h040;
    wait_frame_start();
    repeat (6) @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    chk("midrst_col_out", int'(kp.col_out), 1);
    chk("midrst_key_valid", int'(kp.key_valid), 0);
    chk("midrst_key_code", int'(kp.key_code), 0);
    chk("midrst_key_held", int'(kp.key_held), 0);
    #2 reset_n = 1'b1;
    pulse_mark = pulse_total;
    repeat (4) wait_frame_start();
    repeat (4) @(posedge clk);
    #1;
    chk("after_rst_pulses", pulse_total - pulse_mark, 1);
    chk("after_rst_code", int'(kp.key_code), 8);
    chk("after_rst_held", int'(kp.key_held), 1);

    // disable while held, then re-enable with the key still down
    kp.enable = 1'b0;
    @(posedge clk); #1;
    chk("dis_col_out", int'(kp.col_out), 0);
    chk("dis_key_held", int'(kp.key_held), 0);
    chk("dis_key_valid", int'(kp.key_valid), 0);
    chk("dis_key_code", int'(kp.key_code), 8);
    pulse_mark = pulse_total;
    repeat (40) @(posedge clk);
    #1;
    chk("dis_no_pulses", pulse_total - pulse_mark, 0);
    kp.enable = 1'b1;
    @(posedge clk); #1;
    chk("reen_col_out", int'(kp.col_out), 1);
    repeat (4) wait_frame_start();
    repeat (4) @(posedge clk);
    #1;
    chk("reen_pulses", pulse_total - pulse_mark, 1);
    chk("reen_code", int'(kp.key_code), 8);
    chk("reen_held", int'(kp.key_held), 1);

    chk("pulse_violations", viol, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
